// File: rtl/fifo_link_arbiter.sv
// fifo_link_arbiter
//   Arbitrates four requesters onto a master send-request FIFO and routes
//   lines read back from the master receive-response FIFO to the requester
//   named by the line's 2-bit id field. Limits the number of requests in
//   flight to MAX_OUTSTANDING.
//
// Ports
//   clk, rst_n             single rising-edge clock, async active-low reset
//   i_req_valid/_data      per-requester request valid and payload (slice k)
//   o_req_ready            per-requester accept, combinational, one-hot or 0
//   o_mc_sreq_wen/_inbits  registered write to send FIFO, line = {id, payload}
//   i_mc_sreq_fifo_full    send FIFO full
//   o_mc_rresp_ren         read enable to response FIFO
//   i_mc_rresp_outbits     response line, valid one cycle after ren
//   i_mc_rresp_fifo_empty  response FIFO empty
//   o_resp_valid/_data     response to requester id (id stripped from data)
//   i_resp_ack             per-requester response accept
//   o_outstanding          requests written but not yet acknowledged
//
// Response FSM
//   state     | meaning
//   S_IDLE    | waiting for the response FIFO to go non-empty
//   S_READ    | ren pulse, one cycle
//   S_CAPTURE | response line is on outbits, register it
//   S_DELIVER | present line to requester id until that requester acks
module fifo_link_arbiter #(
  parameter int DATA_LINE_WIDTH = 40,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  input  logic [NUM_REQ*(DATA_LINE_WIDTH-2)-1:0] i_req_data,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  output logic                                   o_mc_sreq_wen,
  output logic [DATA_LINE_WIDTH-1:0]             o_mc_sreq_inbits,
  input  logic                                   i_mc_sreq_fifo_full,
  output logic                                   o_mc_rresp_ren,
  input  logic [DATA_LINE_WIDTH-1:0]             i_mc_rresp_outbits,
  input  logic                                   i_mc_rresp_fifo_empty,
  output logic [NUM_REQ-1:0]                     o_resp_valid,
  output logic [DATA_LINE_WIDTH-3:0]             o_resp_data,
  input  logic [NUM_REQ-1:0]                     i_resp_ack,
  output logic [3:0]                             o_outstanding
);

  localparam int                 DW      = DATA_LINE_WIDTH;
  localparam int                 PW      = DATA_LINE_WIDTH - 2;
  localparam logic [4:0]         MAX_OUT = 5'(MAX_OUTSTANDING);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DELIVER = 2'd3
  } rstate_e;

  rstate_e         state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   inbits_q, inbits_d;
  logic [3:0]      out_q, out_d;
  logic [DW-1:0]   rline_q, rline_d;

  logic            eligible;
  logic            grant_found;
  logic [1:0]      grant_id;
  logic [1:0]      cand;
  logic [4:0]      eff_count;
  logic [1:0]      resp_id;
  logic            ack_ok;
  logic            dec;

  // ---------------- request side ----------------
  // A registered write still pending blocks issue, so writes are spaced at
  // least two cycles apart and the full flag has time to reflect each one.
  always_comb begin
    eff_count   = {1'b0, out_q} + {4'b0, wen_q};
    eligible    = !i_mc_sreq_fifo_full && !wen_q && (eff_count < MAX_OUT);
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    cand        = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!grant_found && i_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    o_req_ready = (eligible && grant_found) ? (ONE << grant_id) : '0;
  end

  always_comb begin
    wen_d    = eligible && grant_found;
    inbits_d = inbits_q;
    rr_ptr_d = rr_ptr_q;
    if (wen_d) begin
      inbits_d = {grant_id, i_req_data[int'(grant_id)*PW +: PW]};
      rr_ptr_d = grant_id + 2'd1;
    end
  end

  // ---------------- outstanding count ----------------
  // Ack of a delivery at count 0 is dropped rather than wrapping.
  always_comb begin
    resp_id = rline_q[DW-1 -: 2];
    ack_ok  = (state_q == S_DELIVER) && i_resp_ack[resp_id];
    dec     = ack_ok && (out_q != 4'd0);
    out_d   = out_q + {3'b0, wen_q} - {3'b0, dec};
  end

  // ---------------- response FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rline_d = rline_q;
    unique case (state_q)
      S_IDLE:    if (!i_mc_rresp_fifo_empty) state_d = S_READ;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        rline_d = i_mc_rresp_outbits;
        state_d = S_DELIVER;
      end
      S_DELIVER: if (ack_ok) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mc_rresp_ren = (state_q == S_READ);
    o_resp_valid   = (state_q == S_DELIVER) ? (ONE << resp_id) : '0;
    o_resp_data    = (state_q == S_DELIVER) ? rline_q[PW-1:0] : '0;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
      wen_q    <= 1'b0;
      inbits_q <= '0;
      out_q    <= 4'd0;
      rline_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      inbits_q <= inbits_d;
      out_q    <= out_d;
      rline_q  <= rline_d;
    end
  end

  assign o_mc_sreq_wen    = wen_q;
  assign o_mc_sreq_inbits = inbits_q;
  assign o_outstanding    = out_q;

endmodule

// File: doc/fifo_link_arbiter.md
FIFO_LINK_ARBITER -- requirements
Module: fifo_link_arbiter

Interface
REQ-001 Parameter DATA_LINE_WIDTH, default 40, the width of a FIFO line in bits.
REQ-002 Parameter NUM_REQ, default 4, the number of requesters; it is fixed at 4 and the ID field is 2 bits.
REQ-003 Parameter MAX_OUTSTANDING, default 8, the maximum number of issued requests without a delivered response; it SHALL be at most FIFO_DEPTH.
REQ-004 Port clk, input, 1 bit: the single clock, rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port i_req_valid, input, 4 bits: per-requester request valid.
REQ-007 Port i_req_data, input, 4*(DATA_LINE_WIDTH-2) bits: payloads, requester k in slice k.
REQ-008 Port o_req_ready, output, 4 bits: per-requester accept, combinational; one-hot or zero.
REQ-009 Port o_mc_sreq_wen, output, 1 bit: write enable to the master send-request FIFO.
REQ-010 Port o_mc_sreq_inbits, output, DATA_LINE_WIDTH bits: the write line {id[1:0], payload}.
REQ-011 Port i_mc_sreq_fifo_full, input, 1 bit: send-request FIFO full.
REQ-012 Port o_mc_rresp_ren, output, 1 bit: read enable to the master receive-response FIFO.
REQ-013 Port i_mc_rresp_outbits, input, DATA_LINE_WIDTH bits: response line, valid one cycle after ren.
REQ-014 Port i_mc_rresp_fifo_empty, input, 1 bit: receive-response FIFO empty.
REQ-015 Port o_resp_valid, output, 4 bits: per-requester response valid, one-hot or zero.
REQ-016 Port o_resp_data, output, DATA_LINE_WIDTH-2 bits: response payload (id stripped).
REQ-017 Port i_resp_ack, input, 4 bits: per-requester response accept.
REQ-018 Port o_outstanding, output, 4 bits: current outstanding count.

Function
REQ-019 Issue eligibility in a cycle: i_mc_sreq_fifo_full==0 AND the effective count < MAX_OUTSTANDING AND no write is pending from the previous cycle.
  - Effective count = outstanding plus a pending registered write.
  - The pending-write condition limits issue to at most one write every 2 cycles, which guarantees the full flag settles.
REQ-020 When eligible, the block SHALL grant the round-robin winner among i_req_valid.
  - Search starts at rr_ptr.
  - o_req_ready[winner]=1 in the same cycle; the transfer occurs on valid&ready.
REQ-021 On a transfer by requester k, the block SHALL register o_mc_sreq_wen=1 and o_mc_sreq_inbits={k[1:0], payload_k} for exactly the next cycle, then set rr_ptr=(k+1) mod 4.
REQ-022 With no grant, rr_ptr SHALL hold, and o_mc_sreq_wen SHALL be 0 the following cycle.
REQ-023 The response FSM states SHALL be IDLE, READ, CAPTURE and DELIVER.
  - IDLE->READ when i_mc_rresp_fifo_empty==0.
  - READ drives o_mc_rresp_ren=1 for one cycle, then ->CAPTURE.
  - CAPTURE registers i_mc_rresp_outbits, then ->DELIVER.
  - DELIVER holds o_resp_valid[id]=1 and o_resp_data stable until i_resp_ack[id]=1, then ->IDLE.
REQ-024 o_mc_rresp_ren SHALL be 1 only in READ, so there is never more than one read per response.
REQ-025 Acks on non-addressed bits and acks outside DELIVER SHALL be ignored.
REQ-026 Counter rules for outstanding:
  - +1 on each o_mc_sreq_wen.
  - -1 on each DELIVER ack.
  - Both in the same cycle: unchanged.
  - Decrement at 0 SHALL saturate at 0 and be ignored.
REQ-027 At outstanding == MAX_OUTSTANDING, o_req_ready SHALL be 0 until a delivery ack.
  - In the ack cycle itself, ready SHALL still be 0, because eligibility uses the registered count.
REQ-028 i_mc_sreq_fifo_full==1 SHALL force o_req_ready=0 in that cycle, regardless of the other conditions.

Reset
REQ-029 rst_n low SHALL asynchronously clear all state and outputs:
  - rr_ptr=0 and FSM=IDLE.
  - Outstanding=0 and the pending write cleared.
  - o_mc_sreq_wen=0, o_mc_sreq_inbits=0, o_mc_rresp_ren=0, o_resp_valid=0, o_resp_data=0.
REQ-030 Reset mid-transaction SHALL discard any captured response and any pending write; operation resumes from IDLE on the first clock after deassertion.

Verification
REQ-031 Single request: requester 2 valid with payload 0x15 -> ready[2] that cycle; next cycle wen=1, inbits={2'b10, 0x15}; outstanding=1.
REQ-032 Fairness: all 4 valid, full=0, responses not returned, MAX_OUTSTANDING=8 -> grant order 0,1,2,3,0,1,2,3; ready stays 0 after 8 issues and outstanding=8.
REQ-033 Backpressure: full=1 for 5 cycles with requester 1 valid -> ready=0 and wen=0 throughout; grant occurs in the first cycle with full=0.
REQ-034 Response routing: FIFO holds line id=3, payload 0x7A, empty=0 -> ren pulses one cycle, then resp_valid=4'b1000 with data 0x7A held until ack[3]; an ack[0] before it is ignored.
REQ-035 Simultaneous events: an issue and a delivery ack in the same cycle at outstanding=5 -> outstanding stays 5.
REQ-036 Reset in DELIVER: assert rst_n=0 with resp_valid high -> resp_valid=0 and outstanding=0 immediately; after release, the FSM is IDLE and the first grant goes to requester 0.
